// File: rtl/wb_arbiter_nx1_pkg.sv
// Shared definitions for the Nx1 Wishbone arbiter: FSM encodings and width helpers.
package wb_arbiter_nx1_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_ERR  = 2'd2;

   // Index width for an N-way selection; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Watchdog counter width; a disabled watchdog still gets a 1-bit counter.
   function automatic int unsigned wdog_width(input int unsigned t);
      return (t == 0) ? 1 : $clog2(t + 1);
   endfunction

endpackage

// File: rtl/wb_arbiter_nx1_rr_arbiter.sv
// Combinational rotate-priority picker: searches req from last+1 (mod N) upward.
module wb_rr_arbiter
   import wb_arbiter_nx1_pkg::*;
#(
   parameter  int unsigned N  = 2,
   localparam int unsigned IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  gnt_nxt,
   output logic [IW-1:0] index
);

   always_comb begin
      logic        found;
      int unsigned k;
      gnt_nxt = '0;
      index   = '0;
      found   = 1'b0;
      k       = 0;
      // The previous owner is visited last, so it only wins when nobody else asks.
      for (int unsigned i = 1; i <= N; i++) begin
         k = (32'(last) + i) % N;
         if (!found && ((req >> k) & N'(1)) != '0) begin
            found   = 1'b1;
            gnt_nxt = N'(1) << k;
            index   = IW'(k);
         end
      end
   end

endmodule

// File: rtl/wb_arbiter_nx1.sv
// Nx1 Wishbone arbiter: round-robin, cyc-locked grant, per-transfer watchdog error.
module wb_arbiter_nx1
   import wb_arbiter_nx1_pkg::*;
#(
   parameter int unsigned N_INITIATORS   = 2,
   parameter int unsigned ADR_WIDTH      = 32,
   parameter int unsigned DAT_WIDTH      = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic [N_INITIATORS*ADR_WIDTH-1:0]   t_adr,
   input  logic [N_INITIATORS*DAT_WIDTH-1:0]   t_dat_w,
   input  logic [N_INITIATORS*DAT_WIDTH/8-1:0] t_sel,
   input  logic [N_INITIATORS-1:0]             t_we,
   input  logic [N_INITIATORS-1:0]             t_cyc,
   input  logic [N_INITIATORS-1:0]             t_stb,
   output logic [N_INITIATORS*DAT_WIDTH-1:0]   t_dat_r,
   output logic [N_INITIATORS-1:0]             t_ack,
   output logic [N_INITIATORS-1:0]             t_err,
   output logic [ADR_WIDTH-1:0]                i_adr,
   output logic [DAT_WIDTH-1:0]                i_dat_w,
   output logic [DAT_WIDTH/8-1:0]              i_sel,
   output logic                                i_we,
   output logic                                i_cyc,
   output logic                                i_stb,
   input  logic [DAT_WIDTH-1:0]                i_dat_r,
   input  logic                                i_ack,
   input  logic                                i_err,
   output logic [N_INITIATORS-1:0]             gnt,
   output logic                                timeout
);

   localparam int unsigned N       = N_INITIATORS;
   localparam int unsigned SEL_W   = DAT_WIDTH / 8;
   localparam int unsigned IW      = idx_width(N);
   localparam int unsigned WW      = wdog_width(TIMEOUT_CYCLES);
   localparam logic        WDOG_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [WW-1:0] WDOG_LIMIT = WDOG_EN ? WW'(TIMEOUT_CYCLES - 1) : '0;

   logic [1:0]    state;
   logic [IW-1:0] gnt_idx;
   logic [IW-1:0] last;
   logic [WW-1:0] wdog;

   logic [N-1:0]  pick_gnt;
   logic [IW-1:0] pick_idx;
   logic          busy;
   logic          in_err;
   logic          own_cyc;
   logic          wdog_run;
   logic          wdog_hit;

   wb_rr_arbiter #(.N(N)) u_rr (
      .req     (t_cyc),
      .last    (last),
      .gnt_nxt (pick_gnt),
      .index   (pick_idx)
   );

   assign busy    = (state == ST_BUSY);
   assign in_err  = (state == ST_ERR);
   assign own_cyc = t_cyc[gnt_idx];

   // Owner dropping cyc releases the bus in that same cycle.
   assign i_cyc   = busy & own_cyc;
   assign i_stb   = busy & own_cyc & t_stb[gnt_idx];
   assign timeout = in_err;

   assign i_adr   = t_adr  [gnt_idx*ADR_WIDTH +: ADR_WIDTH];
   assign i_dat_w = t_dat_w[gnt_idx*DAT_WIDTH +: DAT_WIDTH];
   assign i_sel   = t_sel  [gnt_idx*SEL_W     +: SEL_W];
   assign i_we    = t_we[gnt_idx];

   for (genvar k = 0; k < N; k++) begin : g_slice
      assign t_dat_r[k*DAT_WIDTH +: DAT_WIDTH] = i_dat_r;
      assign t_ack[k] = gnt[k] & busy & i_ack;
      assign t_err[k] = gnt[k] & ((busy & i_err) | in_err);
   end

   // A response arriving on the limit cycle stops wdog_run, so ack/err beat the watchdog.
   assign wdog_run = WDOG_EN & i_stb & ~i_ack & ~i_err;
   assign wdog_hit = wdog_run & (wdog == WDOG_LIMIT);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         gnt     <= '0;
         gnt_idx <= '0;
         last    <= IW'(N - 1);
         wdog    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               wdog <= '0;
               if (|t_cyc) begin
                  gnt     <= pick_gnt;
                  gnt_idx <= pick_idx;
                  state   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (!own_cyc) begin
                  last  <= gnt_idx;
                  gnt   <= '0;
                  wdog  <= '0;
                  state <= ST_IDLE;
               end else if (wdog_hit) begin
                  wdog  <= '0;
                  state <= ST_ERR;
               end else if (wdog_run) begin
                  wdog  <= wdog + WW'(1);
               end else begin
                  wdog  <= '0;
               end
            end
            ST_ERR: begin
               wdog  <= '0;
               state <= ST_BUSY;
            end
            default: begin
               gnt   <= '0;
               wdog  <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
